vga_scan_controller: RTL and testbench

- Second-generation VGA scan controller for a pixel clock supplied on vga_clock.
- Generates sync and blank signals for any timing set through parameters.
- Downscales the 640x480-class raster to dots by a power-of-two factor, computes the video-memory address without a multiplier, and absorbs a configurable memory read latency.
- Expands each BPC-bit colour channel to the DAC width; drives the VGA DAC pins directly, with video memory read through memory_address and pixel_colour.

---
 rtl/vga_pkg.sv | 51 +++++
 rtl/vga_colour_expand.sv | 15 +
 rtl/vga_scan_controller.sv | 212 +++++++++++++++++++++
 tb/tb_vga_scan_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing helpers and colour-bar constants for the VGA scan controller.
// Bar constants serve the optional VGA_TEST_PATTERN_EN build.
package vga_pkg;

    localparam int NUM_BARS = 8;

    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int timing_total(input int active, input int front,
                                        input int sync, input int back);
        return active + front + sync + back;
    endfunction

    function automatic int dot_count(input int pixels, input int shift);
        return pixels >> shift;
    endfunction

    // {R,G,B} on/off for bar index 0 (left) .. 7 (right)
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_colour_expand.sv
// Combinational widening of one colour channel to the DAC width by MSB-first
// bit replication, truncated at the LSB end.
module vga_colour_expand #(
    parameter int BPC   = 2,
    parameter int DAC_W = 10
) (
    input  logic [BPC-1:0]   channel,
    output logic [DAC_W-1:0] dac
);

    for (genvar i = 0; i < DAC_W; i++) begin : g_rep
        assign dac[DAC_W-1-i] = channel[BPC-1-(i % BPC)];
    end

endmodule

// File: rtl/vga_scan_controller.sv
// Parameterised VGA raster/sync generator with downscaled dot addressing and a
// latency-matched control pipeline. Optional colour bars: VGA_TEST_PATTERN_EN.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int SCALE_SHIFT = 1,
    parameter int BPC         = 2,
    parameter int DAC_W       = 10,
    parameter int MEM_LATENCY = 1,
    localparam int DOTS_W     = dot_count(H_ACTIVE, SCALE_SHIFT),
    localparam int DOTS_H     = dot_count(V_ACTIVE, SCALE_SHIFT),
    localparam int ADDR_W     = clog2(DOTS_W * DOTS_H)
) (
    input  logic               vga_clock,
    input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [3*BPC-1:0]   pixel_colour,
    output logic [ADDR_W-1:0]  memory_address,
    output logic               mem_rd_en,
    output logic [DAC_W-1:0]   VGA_R,
    output logic [DAC_W-1:0]   VGA_G,
    output logic [DAC_W-1:0]   VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK,
    output logic               VGA_SYNC,
    output logic               VGA_CLK,
    output logic               frame_start,
    output logic               in_vblank
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HC_W    = clog2(H_TOTAL);
    localparam int VC_W    = clog2(V_TOTAL);
    localparam int PIPE_D  = MEM_LATENCY + 2;

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FRONT);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FRONT);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VC_W-1:0] ROW_MASK = VC_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(DOTS_W);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    typedef struct packed {
        logic hs_act;
        logic vs_act;
        logic visible;
        logic frame_start;
`ifdef VGA_TEST_PATTERN_EN
        logic [HC_W-1:0] x;
`endif
    } ctl_t;

    logic [HC_W-1:0]   hcnt;
    logic [VC_W-1:0]   vcnt;
    logic [ADDR_W-1:0] row_base;
    logic              h_wrap;
    logic              v_wrap;
    logic              active;

    assign h_wrap    = (hcnt == H_LAST);
    assign v_wrap    = (vcnt == V_LAST);
    assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign in_vblank = (vcnt >= V_ACT);
    assign VGA_SYNC  = 1'b1;
    assign VGA_CLK   = vga_clock;

    // row_base advances only after the last raster line of each dot row.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            hcnt     <= '0;
            vcnt     <= '0;
            row_base <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            if (v_wrap) begin
                vcnt     <= '0;
                row_base <= '0;
            end else begin
                vcnt <= vcnt + 1'b1;
                if ((vcnt < V_ACT) && ((vcnt & ROW_MASK) == ROW_MASK))
                    row_base <= row_base + ROW_STEP;
            end
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    logic [ADDR_W-1:0] dot_x;
    assign dot_x = ADDR_W'(hcnt >> SCALE_SHIFT);

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            memory_address <= '0;
            mem_rd_en      <= 1'b0;
        end else begin
            mem_rd_en <= active;
            if (active)
                memory_address <= row_base + dot_x;
        end
    end

    ctl_t ctl_now;
    ctl_t ctl_dac;
    ctl_t [PIPE_D-2:0] ctl_pipe;

    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        ctl_now             = '0;
        ctl_now.hs_act      = (hcnt >= HS_START) && (hcnt < HS_END);
        ctl_now.vs_act      = (vcnt >= VS_START) && (vcnt < VS_END);
        ctl_now.visible     = active;
        ctl_now.frame_start = (hcnt == '0) && (vcnt == '0);
`ifdef VGA_TEST_PATTERN_EN
        ctl_now.x           = hcnt;
`endif
    end

    // NOTE: the delay line is reset as a whole; it is a handful of flops, not a
    // RAM, and a cleared pipe keeps sync and blank inactive right after reset.
    always_ff @(posedge vga_clock) begin
        if (reset)
            ctl_pipe <= '0;
        else
            ctl_pipe <= {ctl_pipe[PIPE_D-3:0], ctl_now};
    end

    assign ctl_dac = ctl_pipe[PIPE_D-2];

    logic [3*BPC-1:0] src_rgb;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb;

    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < NUM_BARS; k++)
            if (ctl_dac.x >= HC_W'(k * H_ACTIVE / NUM_BARS))
                bar_idx = 3'(k);
    end

    assign bar_rgb = bar_colour(bar_idx);
`endif

    always_comb begin
        src_rgb = pixel_colour;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode)
            src_rgb = {{BPC{bar_rgb[2]}}, {BPC{bar_rgb[1]}}, {BPC{bar_rgb[0]}}};
`endif
    end

    logic [DAC_W-1:0] exp_r;
    logic [DAC_W-1:0] exp_g;
    logic [DAC_W-1:0] exp_b;

    vga_colour_expand #(.BPC(BPC), .DAC_W(DAC_W)) u_expand_r (
        .channel (src_rgb[3*BPC-1 -: BPC]),
        .dac     (exp_r)
    );
    vga_colour_expand #(.BPC(BPC), .DAC_W(DAC_W)) u_expand_g (
        .channel (src_rgb[2*BPC-1 -: BPC]),
        .dac     (exp_g)
    );
    vga_colour_expand #(.BPC(BPC), .DAC_W(DAC_W)) u_expand_b (
        .channel (src_rgb[BPC-1:0]),
        .dac     (exp_b)
    );

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~HS_ON;
            VGA_VS      <= ~VS_ON;
            VGA_BLANK   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            VGA_R       <= ctl_dac.visible ? exp_r : '0;
            VGA_G       <= ctl_dac.visible ? exp_g : '0;
            VGA_B       <= ctl_dac.visible ? exp_b : '0;
            VGA_HS      <= ctl_dac.hs_act ? HS_ON : ~HS_ON;
            VGA_VS      <= ctl_dac.vs_act ? VS_ON : ~VS_ON;
            VGA_BLANK   <= ctl_dac.visible;
            frame_start <= ctl_dac.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: a default-timing instance for line-level checks and a tiny
// instance (MEM_LATENCY=3, BPC=3, positive syncs) for whole-frame checks.
module tb_vga_scan_controller;

    logic vga_clock = 1'b0;
    logic reset     = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    logic [5:0]  pix;
    logic [16:0] mem_addr;
    logic        mem_rd_en;
    logic [9:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank, vga_sync, vga_clk, frame_start, in_vblank;

    logic [8:0]  pix_s;
    logic [4:0]  s_addr;
    logic        s_rd;
    logic [9:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_blank, s_sync, s_clk, s_fs, s_vblank;

    vga_scan_controller dut (
        .vga_clock      (vga_clock),
        .reset          (reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode      (test_mode),
`endif
        .pixel_colour   (pix),
        .memory_address (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .VGA_R          (vga_r),
        .VGA_G          (vga_g),
        .VGA_B          (vga_b),
        .VGA_HS         (vga_hs),
        .VGA_VS         (vga_vs),
        .VGA_BLANK      (vga_blank),
        .VGA_SYNC       (vga_sync),
        .VGA_CLK        (vga_clk),
        .frame_start    (frame_start),
        .in_vblank      (in_vblank)
    );

    vga_scan_controller #(
        .H_ACTIVE(12), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_ACTIVE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1), .VS_POL(1), .SCALE_SHIFT(1), .BPC(3), .DAC_W(10), .MEM_LATENCY(3)
    ) dut_s (
        .vga_clock      (vga_clock),
        .reset          (reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode      (1'b0),
`endif
        .pixel_colour   (pix_s),
        .memory_address (s_addr),
        .mem_rd_en      (s_rd),
        .VGA_R          (s_r),
        .VGA_G          (s_g),
        .VGA_B          (s_b),
        .VGA_HS         (s_hs),
        .VGA_VS         (s_vs),
        .VGA_BLANK      (s_blank),
        .VGA_SYNC       (s_sync),
        .VGA_CLK        (s_clk),
        .frame_start    (s_fs),
        .in_vblank      (s_vblank)
    );

    always #5 vga_clock = ~vga_clock;

    function automatic logic [8:0] mem_word_s(input logic [4:0] a);
        return {a[2:0], ~a[2:0], a[4:2]};
    endfunction

    function automatic logic [9:0] rep3(input logic [2:0] c);
        logic [11:0] w;
        w = {4{c}};
        return w[11:2];
    endfunction

    // Synchronous video-memory models: latency 1 (default) and latency 3 (small)
    logic [8:0] mem_s0, mem_s1;
    always @(posedge vga_clock) begin
        pix    <= mem_addr[5:0];
        mem_s0 <= mem_word_s(s_addr);
        mem_s1 <= mem_s0;
        pix_s  <= mem_s1;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge vga_clock);
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (5) @(negedge vga_clock);
        reset = 1'b0;
        cyc = 0;
    endtask

    typedef struct packed {
        int         k;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pin_vec_t;

    typedef struct packed {
        int   k;
        logic rd_en;
        int   addr;
    } mem_vec_t;

    pin_vec_t pin_tab [14];
    mem_vec_t mem_tab [10];

    int   c, hc, vc, last_a, e, e_sync, e_rgb, e_addr, e_vb;
    int   fall1, fall2, low_w, vis;
    logic prev_hs, ehs, evs, evis, efs, erd;
    logic [29:0] ergb;
    logic [8:0]  w;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        // Default DUT: outputs at cycle k reflect the counter at k-3; address at k-1.
        pin_tab = '{
            '{0,    1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{2,    1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{3,    1'b1, 1'b1, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000},
            '{4,    1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{69,   1'b1, 1'b1, 1'b1, 1'b0, 10'h2AA, 10'h000, 10'h155},
            '{129,  1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF},
            '{642,  1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF},
            '{643,  1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{658,  1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{659,  1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{754,  1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{755,  1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{803,  1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000},
            '{1613, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h155, 10'h155}
        };
        mem_tab = '{
            '{0, 1'b0, 0},   '{1, 1'b1, 0},     '{2, 1'b1, 0},      '{3, 1'b1, 1},
            '{640, 1'b1, 319}, '{641, 1'b0, 319}, '{800, 1'b0, 319}, '{801, 1'b1, 0},
            '{1601, 1'b1, 320}, '{1604, 1'b1, 321}
        };

        do_reset();
        run_to(137);
        // Mid-line reset: state must already be cleared while reset is held
        reset = 1'b1;
        repeat (2) @(negedge vga_clock);
        check("reset_ctl", {vga_hs, vga_vs, vga_blank, frame_start, mem_rd_en},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_addr_rgb", {mem_addr, vga_r, vga_g, vga_b}, '0);
        check("reset_small_sync", {s_hs, s_vs, s_blank, s_addr}, '0);
        repeat (3) @(negedge vga_clock);
        reset = 1'b0;
        cyc = 0;
        check("sync_pin", vga_sync, 1'b1);
        check("clk_low", vga_clk, 1'b0);
        #6;
        check("clk_high", vga_clk, 1'b1);
        @(negedge vga_clock);
        cyc = 1;

        foreach (pin_tab[i]) begin
            run_to(pin_tab[i].k);
            check($sformatf("pins@%0d", pin_tab[i].k),
                  {vga_blank, vga_hs, vga_vs, frame_start},
                  {pin_tab[i].blank, pin_tab[i].hs, pin_tab[i].vs, pin_tab[i].fs});
            check($sformatf("rgb@%0d", pin_tab[i].k), {vga_r, vga_g, vga_b},
                  {pin_tab[i].r, pin_tab[i].g, pin_tab[i].b});
        end

        do_reset();
        foreach (mem_tab[i]) begin
            run_to(mem_tab[i].k);
            check($sformatf("mem@%0d", mem_tab[i].k), {mem_rd_en, mem_addr},
                  {mem_tab[i].rd_en, 17'(mem_tab[i].addr)});
        end

        // Line timing: HS falls at k=659 (hcnt 656), 800-clock period, 96 low, 640 visible
        do_reset();
        fall1 = -1; fall2 = -1; low_w = 0; vis = 0;
        prev_hs = vga_hs;
        for (int k = 1; k <= 1700; k++) begin
            tick();
            if (prev_hs && !vga_hs) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            if (!vga_hs && fall1 >= 0 && fall2 < 0) low_w++;
            if (cyc >= 3 && cyc < 803 && vga_blank) vis++;
            prev_hs = vga_hs;
        end
        check("hs_first_fall", fall1, 659);
        check("line_period", fall2 - fall1, 800);
        check("hs_low_width", low_w, 96);
        check("visible_per_line", vis, 640);

        // Address sequence 0,0,1,1,.. over lines 0..2
        do_reset();
        e = 0;
        for (int k = 1; k <= 2400; k++) begin
            tick();
            c = k - 1; hc = c % 800; vc = c / 800;
            if (hc < 640 && (!mem_rd_en || mem_addr !== 17'((vc / 2) * 320 + hc / 2))) e++;
            if (hc == 639) begin
                check($sformatf("addr_seq_line%0d", vc), e, 0);
                e = 0;
            end
        end

        // Small DUT, two full frames against a spec-level model
        do_reset();
        e_sync = 0; e_rgb = 0; e_addr = 0; e_vb = 0; last_a = 0;
        for (int k = 0; k <= 488; k++) begin
            run_to(k);
            c = k - 5;
            ehs = 1'b0; evs = 1'b0; evis = 1'b0; efs = 1'b0; ergb = '0;
            if (c >= 0) begin
                hc = c % 20; vc = (c / 20) % 12;
                ehs  = (hc >= 14 && hc < 18);
                evs  = (vc >= 9 && vc < 11);
                evis = (hc < 12 && vc < 8);
                efs  = (hc == 0 && vc == 0);
                if (evis) begin
                    w = mem_word_s(5'((vc / 2) * 6 + hc / 2));
                    ergb = {rep3(w[8:6]), rep3(w[5:3]), rep3(w[2:0])};
                end
            end
            if ({s_hs, s_vs, s_blank, s_fs} !== {ehs, evs, evis, efs}) e_sync++;
            if ({s_r, s_g, s_b} !== ergb) begin
                if (e_rgb == 0) $display("note: first colour deviation at k=%0d", k);
                e_rgb++;
            end
            c = k - 1;
            erd = 1'b0;
            if (c >= 0) begin
                hc = c % 20; vc = (c / 20) % 12;
                if (hc < 12 && vc < 8) begin
                    erd = 1'b1;
                    last_a = (vc / 2) * 6 + hc / 2;
                end
            end
            if (s_rd !== erd || s_addr !== 5'(last_a)) e_addr++;
            if (s_vblank !== (((k / 20) % 12) >= 8)) e_vb++;
            if (k == 152) check("s_last_addr", s_addr, 23);
            if (k == 241) check("s_frame2_addr", s_addr, 0);
            if (k == 245) check("s_frame2_start", s_fs, 1'b1);
        end
        check("s_sync_errs", e_sync, 0);
        check("s_colour_errs", e_rgb, 0);
        check("s_addr_errs", e_addr, 0);
        check("s_vblank_errs", e_vb, 0);

`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b1;
        do_reset();
        run_to(3);
        check("bar_white_first", {vga_r, vga_g, vga_b}, {30{1'b1}});
        check("bar_rd_en", mem_rd_en, 1'b1);
        run_to(82);
        check("bar_white_last", {vga_r, vga_g, vga_b}, {30{1'b1}});
        run_to(83);
        check("bar_yellow", {vga_r, vga_g, vga_b}, {10'h3FF, 10'h3FF, 10'h000});
        run_to(563);
        check("bar_black_first", {vga_r, vga_g, vga_b}, 30'h0);
        run_to(642);
        check("bar_black_last", {vga_r, vga_g, vga_b}, 30'h0);
        do_reset();
        run_to(68);
        check("bar_before_clear", {vga_r, vga_g, vga_b}, {30{1'b1}});
        test_mode = 1'b0;
        run_to(69);
        check("bar_cleared", {vga_r, vga_g, vga_b}, {10'h2AA, 10'h000, 10'h155});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
